vram_arbiter: RTL and testbench

//  Shares the single VRAM controller port of the video engine between two requesters:

---
 rtl/vram_arbiter_pkg.sv | 23 ++
 rtl/vram_arbiter_if.sv | 34 +++
 rtl/vram_arbiter_rr_arb2.sv | 41 ++++
 rtl/vram_arbiter.sv | 90 +++++++++
 tb/tb_vram_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared VRAM geometry constants, port IDs and the read-return tag type.
package vram_arbiter_pkg;
    localparam int VRAM_ADDR_W = 11;
    localparam int VRAM_X_W    = 6;
    localparam int VRAM_Y_W    = 5;
    localparam int VRAM_DATA_W = 8;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    typedef struct packed {
        logic  vld;
        port_e port;
    } rd_tag_t;

    // VRAM addresses are laid out as {row, column}.
    function automatic logic [VRAM_ADDR_W-1:0] vram_addr(input logic [VRAM_Y_W-1:0] y,
                                                        input logic [VRAM_X_W-1:0] x);
        return {y, x};
    endfunction
endpackage

// File: rtl/vram_arbiter_if.sv
// Requester ports A/B plus the VRAM controller side of the arbiter.
interface vram_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic              i_a_req, i_a_wre, i_a_lock;
    logic [ADDR_W-1:0] i_a_addr;
    logic [DATA_W-1:0] i_a_din;
    logic              o_a_gnt, o_a_rvalid;
    logic [DATA_W-1:0] o_a_rdata;
    logic              i_b_req, i_b_wre, i_b_lock;
    logic [ADDR_W-1:0] i_b_addr;
    logic [DATA_W-1:0] i_b_din;
    logic              o_b_gnt, o_b_rvalid;
    logic [DATA_W-1:0] o_b_rdata;
    logic [ADDR_W-1:0] o_vram_addr;
    logic [DATA_W-1:0] o_vram_din;
    logic [DATA_W-1:0] i_vram_dout;
    logic              o_vram_clk, o_vram_ce, o_vram_wre;

    modport slave (
        input  i_a_req, i_a_wre, i_a_lock, i_a_addr, i_a_din,
        input  i_b_req, i_b_wre, i_b_lock, i_b_addr, i_b_din, i_vram_dout,
        output o_a_gnt, o_a_rvalid, o_a_rdata, o_b_gnt, o_b_rvalid, o_b_rdata,
        output o_vram_addr, o_vram_din, o_vram_clk, o_vram_ce, o_vram_wre
    );

    modport master (
        output i_a_req, i_a_wre, i_a_lock, i_a_addr, i_a_din,
        output i_b_req, i_b_wre, i_b_lock, i_b_addr, i_b_din, i_vram_dout,
        input  o_a_gnt, o_a_rvalid, o_a_rdata, o_b_gnt, o_b_rvalid, o_b_rdata,
        input  o_vram_addr, o_vram_din, o_vram_clk, o_vram_ce, o_vram_wre
    );
endinterface

// File: rtl/vram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; a locked owner keeps priority while it still requests.
module rr_arb2
    import vram_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic [1:0] lock_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);
    port_e last_q, last_d, own_q, own_d, win;
    logic  lk_q, lk_d;

    always_comb begin
        gnt_o = 2'b00;
        if (lk_q && req_i[own_q])
            gnt_o[own_q] = 1'b1;
        else if (req_i == 2'b11)
            gnt_o[~last_q] = 1'b1;
        else
            gnt_o = req_i;
        win = gnt_o[1] ? PORT_B : PORT_A;
        // Any cycle without an acceptance means the owner let go of req.
        lk_d   = accept_i & lock_i[win];
        own_d  = accept_i ? win : own_q;
        last_d = accept_i ? win : last_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= PORT_B;
            own_q  <= PORT_A;
            lk_q   <= 1'b0;
        end else begin
            last_q <= last_d;
            own_q  <= own_d;
            lk_q   <= lk_d;
        end
    end
endmodule

// File: rtl/vram_arbiter.sv
// Shares one VRAM command port between requesters A and B; read data is tagged
// through an RD_LAT-deep pipe and returned only to the issuing port.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W,
    parameter int RD_LAT = 1
) (
    input logic           i_clk,
    input logic           i_rst,
    vram_arbiter_if.slave bus
);
    logic [1:0]        req, lock, gnt;
    logic              accept;
    port_e             sel;
    logic              ce_q, ce_d, wre_q, wre_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    rd_tag_t           tag_pipe_q [RD_LAT:0];
    rd_tag_t           ret;
    logic              a_rvalid_q, b_rvalid_q;
    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

    assign req    = {bus.i_b_req, bus.i_a_req};
    assign lock   = {bus.i_b_lock, bus.i_a_lock};
    assign accept = |(req & gnt);
    assign sel    = gnt[1] ? PORT_B : PORT_A;

    rr_arb2 u_arb (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .req_i    (req),
        .lock_i   (lock),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    always_comb begin
        ce_d   = accept;
        wre_d  = wre_q;
        addr_d = addr_q;
        din_d  = din_q;
        if (accept) begin
            wre_d  = (sel == PORT_B) ? bus.i_b_wre  : bus.i_a_wre;
            addr_d = (sel == PORT_B) ? bus.i_b_addr : bus.i_a_addr;
            din_d  = (sel == PORT_B) ? bus.i_b_din  : bus.i_a_din;
        end
    end

    // Stage 0 lines up with o_vram_ce; stage RD_LAT lines up with valid i_vram_dout.
    assign ret = tag_pipe_q[RD_LAT];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ce_q       <= 1'b0;
            wre_q      <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            for (int k = 0; k <= RD_LAT; k++) tag_pipe_q[k] <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            ce_q          <= ce_d;
            wre_q         <= wre_d;
            addr_q        <= addr_d;
            din_q         <= din_d;
            tag_pipe_q[0] <= rd_tag_t'{vld: accept & ~wre_d, port: sel};
            for (int k = 1; k <= RD_LAT; k++) tag_pipe_q[k] <= tag_pipe_q[k-1];
            a_rvalid_q    <= ret.vld && (ret.port == PORT_A);
            b_rvalid_q    <= ret.vld && (ret.port == PORT_B);
            if (ret.vld && (ret.port == PORT_A)) a_rdata_q <= bus.i_vram_dout;
            if (ret.vld && (ret.port == PORT_B)) b_rdata_q <= bus.i_vram_dout;
        end
    end

    assign bus.o_a_gnt     = gnt[0];
    assign bus.o_b_gnt     = gnt[1];
    assign bus.o_a_rvalid  = a_rvalid_q;
    assign bus.o_b_rvalid  = b_rvalid_q;
    assign bus.o_a_rdata   = a_rdata_q;
    assign bus.o_b_rdata   = b_rdata_q;
    assign bus.o_vram_clk  = i_clk;
    assign bus.o_vram_ce   = ce_q;
    assign bus.o_vram_wre  = wre_q;
    assign bus.o_vram_addr = addr_q;
    assign bus.o_vram_din  = din_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Drives two arbiters (RD_LAT=1 and RD_LAT=3) with identical requests and checks
// both against a cycle-indexed reference of grants, VRAM commands and read returns.
module tb_vram_arbiter;
    import vram_arbiter_pkg::*;
    localparam int AW = 11;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst, mem_init;
    always #5 clk = ~clk;

    logic          a_req, a_wre, a_lock, b_req, b_wre, b_lock;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_din, b_din;

    vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1.slave));
    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_dut3 (.i_clk(clk), .i_rst(rst), .bus(bus3.slave));

    assign bus1.i_a_req = a_req;   assign bus3.i_a_req = a_req;
    assign bus1.i_a_wre = a_wre;   assign bus3.i_a_wre = a_wre;
    assign bus1.i_a_lock = a_lock; assign bus3.i_a_lock = a_lock;
    assign bus1.i_a_addr = a_addr; assign bus3.i_a_addr = a_addr;
    assign bus1.i_a_din = a_din;   assign bus3.i_a_din = a_din;
    assign bus1.i_b_req = b_req;   assign bus3.i_b_req = b_req;
    assign bus1.i_b_wre = b_wre;   assign bus3.i_b_wre = b_wre;
    assign bus1.i_b_lock = b_lock; assign bus3.i_b_lock = b_lock;
    assign bus1.i_b_addr = b_addr; assign bus3.i_b_addr = b_addr;
    assign bus1.i_b_din = b_din;   assign bus3.i_b_din = b_din;

    function automatic logic [DW-1:0] init_val(input int i);
        return 8'(i * 7 + 3);
    endfunction

    // VRAM models: read data appears RD_LAT cycles after the ce cycle.
    logic [DW-1:0] vmem1 [2048];
    logic [DW-1:0] vmem3 [2048];
    logic [DW-1:0] p1;
    logic [DW-1:0] p3 [3];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 2048; i++) begin
                vmem1[i] <= init_val(i);
                vmem3[i] <= init_val(i);
            end
        end else begin
            if (bus1.o_vram_ce && bus1.o_vram_wre) vmem1[bus1.o_vram_addr] <= bus1.o_vram_din;
            if (bus1.o_vram_ce && !bus1.o_vram_wre) p1 <= vmem1[bus1.o_vram_addr];
            if (bus3.o_vram_ce && bus3.o_vram_wre) vmem3[bus3.o_vram_addr] <= bus3.o_vram_din;
            p3[0] <= vmem3[bus3.o_vram_addr];
            p3[1] <= p3[0];
            p3[2] <= p3[1];
        end
    end
    assign bus1.i_vram_dout = p1;
    assign bus3.i_vram_dout = p3[2];

    // Reference state: [d] selects the RD_LAT=1 / RD_LAT=3 instance, [p] the port.
    int            n_cmp = 0, n_err = 0, cyc = 0;
    int            m_last, m_own;
    bit            m_lk;
    logic          e_ce, e_wre;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    logic [DW-1:0] rmem [2048];
    bit            ev [2][2][4096];
    logic [DW-1:0] ed [2][2][4096];
    logic [DW-1:0] hold [2][2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_last = 1; m_own = 0; m_lk = 0;
        e_ce = 0; e_wre = 0; e_addr = '0; e_din = '0;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                hold[d][p] = '0;
                for (int c = 0; c < 4096; c++) ev[d][p][c] = 0;
            end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_1"}, 64'({bus1.o_vram_ce, bus1.o_vram_wre, bus1.o_vram_addr, bus1.o_vram_din,
                              bus1.o_a_rvalid, bus1.o_b_rvalid, bus1.o_a_rdata, bus1.o_b_rdata}), 64'd0);
        chk({tag, "_3"}, 64'({bus3.o_vram_ce, bus3.o_vram_wre, bus3.o_vram_addr, bus3.o_vram_din,
                              bus3.o_a_rvalid, bus3.o_b_rvalid, bus3.o_a_rdata, bus3.o_b_rdata}), 64'd0);
    endtask

    // One clock: inputs already set at posedge+1; check grant mid-cycle, outputs after the edge.
    task automatic step(output logic [1:0] og);
        logic [1:0]    r, eg;
        int            win;
        logic          w, lk;
        logic [AW-1:0] ad;
        logic [DW-1:0] dn;
        #2;
        r = {b_req, a_req};
        if (r == 2'b00)              win = -1;
        else if (m_lk && r[m_own])   win = m_own;
        else if (r == 2'b11)         win = 1 - m_last;
        else                         win = r[1] ? 1 : 0;
        eg = (win < 0) ? 2'b00 : ((win == 1) ? 2'b10 : 2'b01);
        og = {bus1.o_b_gnt, bus1.o_a_gnt};
        chk("gnt_1", 64'(og), 64'(eg));
        chk("gnt_3", 64'({bus3.o_b_gnt, bus3.o_a_gnt}), 64'(eg));
        if (win >= 0) begin
            w  = win ? b_wre  : a_wre;
            ad = win ? b_addr : a_addr;
            dn = win ? b_din  : a_din;
            lk = win ? b_lock : a_lock;
            e_ce = 1; e_wre = w; e_addr = ad; e_din = dn;
            if (w) rmem[ad] = dn;
            else begin
                ev[0][win][cyc+3] = 1; ed[0][win][cyc+3] = rmem[ad];
                ev[1][win][cyc+5] = 1; ed[1][win][cyc+5] = rmem[ad];
            end
            m_lk = lk; m_own = win; m_last = win;
        end else begin
            e_ce = 0; m_lk = 0;
        end
        @(posedge clk);
        cyc++;
        #1;
        chk("cmd_1", 64'({bus1.o_vram_ce, bus1.o_vram_wre, bus1.o_vram_addr, bus1.o_vram_din}),
                     64'({e_ce, e_wre, e_addr, e_din}));
        chk("cmd_3", 64'({bus3.o_vram_ce, bus3.o_vram_wre, bus3.o_vram_addr, bus3.o_vram_din}),
                     64'({e_ce, e_wre, e_addr, e_din}));
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++)
                if (ev[d][p][cyc]) hold[d][p] = ed[d][p][cyc];
        chk("ret_a1", 64'({bus1.o_a_rvalid, bus1.o_a_rdata}), 64'({ev[0][0][cyc], hold[0][0]}));
        chk("ret_b1", 64'({bus1.o_b_rvalid, bus1.o_b_rdata}), 64'({ev[0][1][cyc], hold[0][1]}));
        chk("ret_a3", 64'({bus3.o_a_rvalid, bus3.o_a_rdata}), 64'({ev[1][0][cyc], hold[1][0]}));
        chk("ret_b3", 64'({bus3.o_b_rvalid, bus3.o_b_rdata}), 64'({ev[1][1][cyc], hold[1][1]}));
    endtask

    task automatic idle(input int n);
        logic [1:0] og;
        a_req = 0; b_req = 0;
        for (int i = 0; i < n; i++) step(og);
    endtask

    task automatic do_reset();
        rst = 1; a_req = 0; b_req = 0;
        #1;
        chk_zero("rst_async");
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst_hold");
        rst = 0;
    endtask

    initial begin
        logic [1:0] og;
        int         nb;
        bit         ag;
        rst = 1; mem_init = 1;
        a_req = 0; a_wre = 0; a_lock = 0; a_addr = '0; a_din = '0;
        b_req = 0; b_wre = 0; b_lock = 0; b_addr = '0; b_din = '0;
        for (int i = 0; i < 2048; i++) rmem[i] = init_val(i);
        m_reset();
        @(posedge clk); #1;
        mem_init = 0;
        chk_zero("rst_init");
        chk("vclk_hi", 64'({bus1.o_vram_clk, bus3.o_vram_clk}), 64'b11);
        #5;
        chk("vclk_lo", 64'({bus1.o_vram_clk, bus3.o_vram_clk}), 64'b00);
        @(posedge clk); #1;
        rst = 0;

        // Idle after reset
        idle(100);

        // Single A write to {3,10}
        a_req = 1; a_wre = 1; a_lock = 0; a_addr = vram_addr(5'd3, 6'd10); a_din = 8'h41;
        step(og);
        chk("t2_gnt", 64'(og), 64'b01);
        chk("t2_cmd", 64'({bus1.o_vram_ce, bus1.o_vram_wre, bus1.o_vram_addr, bus1.o_vram_din}),
                      64'({1'b1, 1'b1, 11'h0CA, 8'h41}));
        idle(2);

        // Both ports from reset alternate A,B,A,B with ce every cycle
        do_reset();
        a_req = 1; b_req = 1; a_lock = 0; b_lock = 0;
        for (int i = 0; i < 10; i++) begin
            a_wre = 1'($urandom_range(0, 1)); a_addr = 11'($urandom_range(256, 511)); a_din = 8'($urandom);
            b_wre = 1'($urandom_range(0, 1)); b_addr = 11'($urandom_range(256, 511)); b_din = 8'($urandom);
            step(og);
            chk("t3_alt", 64'(og), (i % 2 == 0) ? 64'b01 : 64'b10);
            chk("t3_ce", 64'(bus1.o_vram_ce), 64'd1);
        end
        idle(6);

        // Locked B burst of reads of 0x0CA while A keeps requesting
        a_req = 1; a_wre = 1; a_addr = 11'h300; a_din = 8'h11; a_lock = 0;
        step(og);
        a_addr = 11'h301; a_din = 8'h99;
        b_req = 1; b_wre = 0; b_addr = 11'h0CA; b_lock = 1;
        nb = 0; ag = 0;
        for (int i = 0; i < 8 && !ag; i++) begin
            step(og);
            if (og == 2'b10) begin
                nb++;
                if (nb == 4) begin b_req = 0; b_lock = 0; end
            end else if (og == 2'b01) ag = 1;
        end
        a_req = 0;
        chk("t4_nb", 64'(nb), 64'd4);
        chk("t4_ag", 64'(ag), 64'd1);
        idle(6);
        chk("t4_rd", 64'({bus1.o_b_rdata, bus3.o_b_rdata}), 64'({8'h41, 8'h41}));

        // Interleaved reads A(0), B(1), A(2)
        b_req = 1; b_wre = 1; b_addr = 11'h302; b_din = 8'h22;
        step(og);
        a_req = 1; a_wre = 0; a_addr = 11'h000;
        b_req = 1; b_wre = 0; b_addr = 11'h001;
        step(og);
        chk("t5_g0", 64'(og), 64'b01);
        a_addr = 11'h002;
        step(og);
        chk("t5_g1", 64'(og), 64'b10);
        b_req = 0;
        step(og);
        chk("t5_g2", 64'(og), 64'b01);
        idle(8);
        chk("t5_rd1", 64'({bus1.o_a_rdata, bus1.o_b_rdata}), 64'({init_val(2), init_val(1)}));
        chk("t5_rd3", 64'({bus3.o_a_rdata, bus3.o_b_rdata}), 64'({init_val(2), init_val(1)}));

        // Reset with two reads in flight
        a_req = 1; a_wre = 0; a_addr = 11'h005;
        step(og);
        a_req = 0; b_req = 1; b_wre = 0; b_addr = 11'h006;
        step(og);
        do_reset();
        idle(10);

        // Randomized traffic; a request is held until granted
        og = 2'b00;
        for (int i = 0; i < 400; i++) begin
            if (!a_req || og[0]) begin
                a_req = ($urandom_range(0, 2) != 0); a_wre = 1'($urandom_range(0, 1));
                a_lock = ($urandom_range(0, 3) == 0); a_addr = 11'($urandom_range(0, 15)); a_din = 8'($urandom);
            end
            if (!b_req || og[1]) begin
                b_req = ($urandom_range(0, 2) != 0); b_wre = 1'($urandom_range(0, 1));
                b_lock = ($urandom_range(0, 3) == 0); b_addr = 11'($urandom_range(0, 15)); b_din = 8'($urandom);
            end
            step(og);
        end
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
